// File: rtl/seq_mul_pkg.sv
// ---------------------------------------------------------------------------
// seq_mul_pkg
//   Shared definitions for the parametrised shift-add sequential multiplier.
//   - state_e   : control FSM states (IDLE -> BUSY -> FIX -> IDLE)
//   - cnt_width : iteration-counter width for a given operand width; the
//                 counter must be able to hold the value WIDTH.
// ---------------------------------------------------------------------------
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// ---------------------------------------------------------------------------
// seq_mul_dp
//   Datapath of the sequential multiplier. Works on operand magnitudes and
//   applies the sign once, at the end, so signed and unsigned requests share
//   one unsigned shift-add loop.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high; clears all datapath state
//   load_i       in   latch operand magnitudes and sign, clear accumulator
//   step_i       in   one shift-add iteration
//   fix_i        in   write signed/unsigned result to prod_o
//   is_signed_i  in   operands are two's-complement (sampled with load_i)
//   q_i          in   multiplier operand
//   m_i          in   multiplicand operand
//   prod_o       out  2*WIDTH result, changes only on fix_i or reset
// ---------------------------------------------------------------------------
module seq_mul_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               fix_i,
  input  logic               is_signed_i,
  input  logic [WIDTH-1:0]   q_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [WIDTH-1:0]   mq_q,   mq_d;
  logic [2*WIDTH-1:0] mm_q,   mm_d;
  logic [2*WIDTH-1:0] acc_q,  acc_d;
  logic               neg_q,  neg_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  // Magnitude in WIDTH unsigned bits. The most negative value negates to
  // itself in two's complement, which read as unsigned is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    if (sgn && x[WIDTH-1]) begin
      return ~x + WIDTH'(1);
    end
    return x;
  endfunction

  // Final sign application; negating zero yields zero so no -0 case exists.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic               neg);
    if (neg) begin
      return ~mag + (2*WIDTH)'(1);
    end
    return mag;
  endfunction

  always_comb begin
    mq_d   = mq_q;
    mm_d   = mm_q;
    acc_d  = acc_q;
    neg_d  = neg_q;
    prod_d = prod_q;
    if (load_i) begin
      mq_d  = magnitude(q_i, is_signed_i);
      mm_d  = {{WIDTH{1'b0}}, magnitude(m_i, is_signed_i)};
      acc_d = '0;
      neg_d = is_signed_i & (q_i[WIDTH-1] ^ m_i[WIDTH-1]);
    end else if (step_i) begin
      // Multiplicand is pre-shifted each step instead of indexing by the
      // counter; the accumulator cannot overflow 2*WIDTH bits.
      if (mq_q[0]) begin
        acc_d = acc_q + mm_q;
      end
      mm_d = mm_q << 1;
      mq_d = mq_q >> 1;
    end else if (fix_i) begin
      prod_d = apply_sign(acc_q, neg_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mq_q   <= '0;
      mm_q   <= '0;
      acc_q  <= '0;
      neg_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      mq_q   <= mq_d;
      mm_q   <= mm_d;
      acc_q  <= acc_d;
      neg_q  <= neg_d;
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/seq_mul_param.sv
// ---------------------------------------------------------------------------
// seq_mul_param
//   Radix-2 shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH,
//   unsigned or two's-complement per request. One multiply in flight; fixed
//   latency of WIDTH+1 cycles from accepted start to done.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; aborts any multiply in flight
//   start      in   request, sampled only while ready=1
//   is_signed  in   operands are two's-complement (sampled with start)
//   q          in   multiplier operand (sampled with start)
//   m          in   multiplicand operand (sampled with start)
//   ready      out  idle, a request will be accepted
//   busy       out  multiply in progress (== !ready)
//   done       out  one-cycle pulse, prod updated this cycle
//   prod       out  result, held until the next done
// ---------------------------------------------------------------------------
module seq_mul_param
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   m,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             done_q,  done_d;
  logic             load, step, fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Always exactly WIDTH iterations: no early exit on zero multiplier
        // bits, so latency never depends on operand values.
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        fix     = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  seq_mul_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .step_i      (step),
    .fix_i       (fix),
    .is_signed_i (is_signed),
    .q_i         (q),
    .m_i         (m),
    .prod_o      (prod)
  );

  // done is registered alongside the prod write, so both change on the
  // same edge and the request in the done cycle already sees IDLE.
  assign ready = (state_q == ST_IDLE);
  assign busy  = ~ready;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_mul_param.sv
module tb_seq_mul_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        sg;
  logic [15:0] opq, opm;
  logic        start8, start16, start3;

  logic        ready8,  busy8,  done8;
  logic        ready16, busy16, done16;
  logic        ready3,  busy3,  done3;
  logic [15:0] prod8;
  logic [31:0] prod16;
  logic [5:0]  prod3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_mul_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sg),
    .q(opq[7:0]), .m(opm[7:0]),
    .ready(ready8), .busy(busy8), .done(done8), .prod(prod8)
  );

  seq_mul_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .is_signed(sg),
    .q(opq), .m(opm),
    .ready(ready16), .busy(busy16), .done(done16), .prod(prod16)
  );

  seq_mul_param #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .is_signed(sg),
    .q(opq[2:0]), .m(opm[2:0]),
    .ready(ready3), .busy(busy3), .done(done3), .prod(prod3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: the integer product q*m, wrapped to 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input bit s,
                                          input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, p, span;
    span = longint'(1) << w;
    sa = longint'(a) % span;
    sb = longint'(b) % span;
    if (s && sa >= span / 2) sa -= span;
    if (s && sb >= span / 2) sb -= span;
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      8:       return done8;
      16:      return done16;
      default: return done3;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      8:       return busy8;
      16:      return busy16;
      default: return busy3;
    endcase
  endfunction

  function automatic logic get_ready(input int w);
    case (w)
      8:       return ready8;
      16:      return ready16;
      default: return ready3;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int w);
    case (w)
      8:       return {16'b0, prod8};
      16:      return prod16;
      default: return {26'b0, prod3};
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      8:       start8  = v;
      16:      start16 = v;
      default: start3  = v;
    endcase
  endtask

  // One request from idle; checks latency, busy duration, prod hold, result
  // and that done is a single-cycle pulse.
  task automatic do_op(input int w, input bit s, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp, input string tag);
    int n, nb;
    bit seen, stable;
    logic [31:0] p0;
    @(negedge clk);
    check({tag, "_ready"}, 32'(get_ready(w)), 32'd1);
    p0 = get_prod(w);
    sg = s; opq = a; opm = b;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    nb = get_busy(w) ? 1 : 0;
    n = 0; seen = 0; stable = 1;
    while (!seen && n < 200) begin
      if (get_prod(w) != p0) stable = 0;
      @(posedge clk); #1;
      n++;
      if (get_done(w)) seen = 1;
      else if (get_busy(w)) nb++;
    end
    check({tag, "_seen"},    32'(seen), 32'd1);
    check({tag, "_lat"},     32'(n), 32'(w + 1));
    check({tag, "_busy"},    32'(nb), 32'(w + 1));
    check({tag, "_hold"},    32'(stable), 32'd1);
    check({tag, "_prod"},    get_prod(w), exp);
    @(posedge clk); #1;
    check({tag, "_pulse"},   32'(get_done(w)), 32'd0);
  endtask

  initial begin
    int t, nd, last;
    bit s;
    logic [15:0] a, b;

    reset = 1'b1; sg = 1'b0; opq = '0; opm = '0;
    start8 = 1'b0; start16 = 1'b0; start3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_prod8",  {16'b0, prod8}, 32'd0);
    check("rst_prod16", prod16, 32'd0);
    check("rst_prod3",  {26'b0, prod3}, 32'd0);
    check("rst_done",   {29'b0, done8, done16, done3}, 32'd0);
    check("rst_busy",   {29'b0, busy8, busy16, busy3}, 32'd0);
    check("rst_ready",  {29'b0, ready8, ready16, ready3}, 32'd7);
    @(negedge clk);
    reset = 1'b0;

    // Basic unsigned and signed cases
    do_op(8, 0, 16'd20,   16'd10,   32'h0000_00C8, "u20x10");
    do_op(8, 1, 16'h00FD, 16'd7,    32'h0000_FFEB, "sm3x7");
    do_op(8, 1, 16'h0080, 16'h0080, 32'h0000_4000, "smin_sq");
    do_op(8, 0, 16'h00FF, 16'h00FF, 32'h0000_FE01, "umax_sq");

    // Start held high: one result every WIDTH+2 cycles
    @(negedge clk);
    sg = 0; opq = 16'd5; opm = 16'd6; start8 = 1'b1;
    t = 0; nd = 0; last = -1;
    while (nd < 3 && t < 100) begin
      @(posedge clk); #1;
      t++;
      if (done8) begin
        check("cont_prod", {16'b0, prod8}, 32'd30);
        if (last >= 0) check("cont_gap", 32'(t - last), 32'd10);
        else           check("cont_first", 32'(t), 32'd10);
        last = t;
        nd++;
      end
    end
    check("cont_count", 32'(nd), 32'd3);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    check("cont_stop", {31'b0, busy8}, 32'd0);

    // Start pulse during busy with new operands is ignored
    @(negedge clk);
    opq = 16'd5; opm = 16'd6; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    opq = 16'd9; opm = 16'd9; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    t = 3;
    while (!done8 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("ign_lat",  32'(t), 32'd9);
    check("ign_prod", {16'b0, prod8}, 32'd30);
    nd = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    check("ign_nodone", 32'(nd), 32'd0);

    // Reset in the 4th BUSY cycle discards the multiply
    @(negedge clk);
    opq = 16'd9; opm = 16'd9; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_busy",  {31'b0, busy8}, 32'd0);
    check("mrst_done",  {31'b0, done8}, 32'd0);
    check("mrst_prod",  {16'b0, prod8}, 32'd0);
    check("mrst_ready", {31'b0, ready8}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    do_op(8, 0, 16'd2, 16'd3, 32'd6, "after_rst");

    // Zero operand against most negative value
    do_op(8, 1, 16'd0, 16'h0080, 32'd0, "zero_min");

    // Random pairs on the other widths, biased toward edge values
    for (int i = 0; i < 4000; i++) begin
      int w;
      w = (i < 2000) ? 16 : 3;
      s = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: a = 16'd0;
        1: a = 16'(32'd1 << (w - 1));
        2: a = 16'hFFFF;
        3: b = 16'(32'd1 << (w - 1));
        default: ;
      endcase
      do_op(w, s, a, b, ref_mul(w, s, a, b), (w == 16) ? "r16" : "r3");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
